// File: rtl/seg7_scan_mux.sv
// Six-digit multiplexed 7-segment driver: per-frame snapshot, per-slot blanking, active-low bus.
// Optional LEADING_ZERO_BLANK_EN: suppress the hours-tens digit when it shows zero.
module seg7_scan_mux #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] HRM,
    input  logic [6:0] HRL,
    input  logic [6:0] MIN_M,
    input  logic [6:0] MIN_L,
    input  logic [6:0] SEC_M,
    input  logic [6:0] SEC_L,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int unsigned     CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          run;
    logic [6:0]    snap [6];

    logic       past_blank;
    logic       blank_digit;
    logic       show;
    logic       wrap;
    logic [6:0] cur;

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = 32'(cnt) >= BLANK_CYC;
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_digit = (idx == 3'd0) && (snap[0] == 7'b0000001);
`else
    assign blank_digit = 1'b0;
`endif

    assign show = run && past_blank && !blank_digit;
    assign wrap = (cnt == LAST) && (idx == 3'd5);

    always_comb begin
        cur = 7'h7F;
        case (idx)
            3'd0:    cur = snap[0];
            3'd1:    cur = snap[1];
            3'd2:    cur = snap[2];
            3'd3:    cur = snap[3];
            3'd4:    cur = snap[4];
            3'd5:    cur = snap[5];
            default: cur = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 3'd0;
            run         <= 1'b0;
            for (int i = 0; i < 6; i++) snap[i] <= 7'h7F;
            seg         <= 7'h7F;
            an          <= 6'b111111;
            frame_start <= 1'b0;
        end else if (!en) begin
            cnt         <= '0;
            idx         <= 3'd0;
            run         <= 1'b0;
            seg         <= 7'h7F;
            an          <= 6'b111111;
            frame_start <= 1'b0;
        end else begin
            // outputs follow the pre-edge slot position, so the wrap edge still shows the old SEC_L
            if (show) begin
                an  <= ~(6'b100000 >> idx);
                seg <= cur;
            end else begin
                an  <= 6'b111111;
                seg <= 7'h7F;
            end

            if (!run || wrap) begin
                snap[0]     <= HRM;
                snap[1]     <= HRL;
                snap[2]     <= MIN_M;
                snap[3]     <= MIN_L;
                snap[4]     <= SEC_M;
                snap[5]     <= SEC_L;
                cnt         <= '0;
                idx         <= 3'd0;
                run         <= 1'b1;
                frame_start <= 1'b1;
            end else begin
                frame_start <= 1'b0;
                if (cnt == LAST) begin
                    cnt <= '0;
                    idx <= idx + 3'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (8/2 and 2/0) against a slot-arithmetic reference model.
module tb_seg7_scan_mux;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] din [6];

    logic [6:0] seg_a, seg_b;
    logic [5:0] an_a, an_b;
    logic       fs_a, fs_b;

    int errors = 0;
    int checks = 0;

    seg7_scan_mux #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .HRM(din[0]), .HRL(din[1]), .MIN_M(din[2]), .MIN_L(din[3]), .SEC_M(din[4]), .SEC_L(din[5]),
        .seg(seg_a), .an(an_a), .frame_start(fs_a)
    );

    seg7_scan_mux #(.SCAN_DIV(2), .BLANK_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .HRM(din[0]), .HRL(din[1]), .MIN_M(din[2]), .MIN_L(din[3]), .SEC_M(din[4]), .SEC_L(din[5]),
        .seg(seg_b), .an(an_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: position within the frame counted in edges since frame start
    int         sd [2] = '{8, 2};
    int         bl [2] = '{2, 0};
    int         pos [2];
    bit         active [2];
    logic [6:0] msnap [2][6];
    logic [6:0] e_seg [2];
    logic [5:0] e_an [2];
    logic       e_fs [2];

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            active[m] = 1'b0;
            pos[m]    = 0;
            for (int d = 0; d < 6; d++) msnap[m][d] = 7'h7F;
            e_seg[m] = 7'h7F;
            e_an[m]  = 6'b111111;
            e_fs[m]  = 1'b0;
        end
    endtask

    task automatic model_out(input int m, input int q);
        int  slot;
        int  off;
        bit  lit;
        slot = q / sd[m];
        off  = q % sd[m];
        lit  = off >= bl[m];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 0 && msnap[m][0] == 7'b0000001) lit = 1'b0;
`endif
        if (lit) begin
            e_an[m]  = 6'b111111;
            e_an[m][5 - slot] = 1'b0;
            e_seg[m] = msnap[m][slot];
        end else begin
            e_an[m]  = 6'b111111;
            e_seg[m] = 7'h7F;
        end
    endtask

    task automatic model_edge(input int m);
        if (rst) begin
            model_reset();
        end else if (!en) begin
            active[m] = 1'b0;
            e_seg[m]  = 7'h7F;
            e_an[m]   = 6'b111111;
            e_fs[m]   = 1'b0;
        end else if (active[m]) begin
            model_out(m, pos[m]);
            if (pos[m] + 1 == 6 * sd[m]) begin
                e_fs[m] = 1'b1;
                for (int d = 0; d < 6; d++) msnap[m][d] = din[d];
                pos[m] = 0;
            end else begin
                e_fs[m] = 1'b0;
                pos[m]  = pos[m] + 1;
            end
        end else begin
            e_seg[m]  = 7'h7F;
            e_an[m]   = 6'b111111;
            e_fs[m]   = 1'b1;
            for (int d = 0; d < 6; d++) msnap[m][d] = din[d];
            pos[m]    = 0;
            active[m] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("seg_a", seg_a, e_seg[0]);
        chk("an_a", 7'(an_a), 7'(e_an[0]));
        chk("fs_a", 7'(fs_a), 7'(e_fs[0]));
        chk("seg_b", seg_b, e_seg[1]);
        chk("an_b", 7'(an_b), 7'(e_an[1]));
        chk("fs_b", 7'(fs_b), 7'(e_fs[1]));
        chk("onehot_b", 7'($countones(~an_b) <= 1), 7'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    function automatic logic [6:0] rand_pat();
        case ($urandom_range(0, 3))
            0:       rand_pat = 7'b0000001;
            1:       rand_pat = 7'b1001111;
            default: rand_pat = 7'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        for (int d = 0; d < 6; d++) din[d] = 7'h7F;
        model_reset();
        #2;
        check_all();
        #10 rst = 1'b0;
        step();
        step();

        // basic frame with directed digits; SEC_L changes while slot 2 is displayed
        din[0] = 7'b0000001; din[1] = 7'b1001111; din[2] = 7'b0010010;
        din[3] = 7'b0000110; din[4] = 7'b1001100; din[5] = 7'b0000100;
        en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        din[5] = 7'b0000001;
        for (int i = 0; i < 90; i++) step();

        // en drop during slot 3 of the 8-cycle instance
        for (int i = 0; i < 60 && (pos[0] / 8) != 3; i++) step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        for (int i = 0; i < 60; i++) step();

        // asynchronous reset between edges, mid-slot
        for (int i = 0; i < 20 && (pos[0] % 8) != 4; i++) step();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 60; i++) step();

        // leading-zero cases on HRM
        din[0] = 7'b1001111;
        for (int i = 0; i < 100; i++) step();
        din[0] = 7'b0000001;
        for (int i = 0; i < 100; i++) step();

        // randomized traffic with occasional enable drops
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) din[$urandom_range(0, 5)] = rand_pat();
            if ($urandom_range(0, 149) == 0) begin
                en = 1'b0;
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) step();
                en = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
